// File: rtl/rng_arbiter.sv
// rng_arbiter: round-robin arbiter that hands out LFSR random words to stochastic update lanes
module rng_arbiter #(
    parameter int          N_REQ  = 4,
    parameter int          RAND_W = 10,
    parameter int          WARMUP = 64,
    parameter logic [63:0] SEED   = 64'h0123_4567_89AB_CDEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_valid,
    input  logic [63:0]       seed_in,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  grant,
    output logic              rand_valid,
    output logic [RAND_W-1:0] rand_out,
    output logic              ready
);
    localparam int PW = $clog2(N_REQ);

    typedef enum logic [1:0] {WARM, READY, REFILL} state_t;

    state_t      state;
    logic [63:0] lfsr;
    logic [63:0] lfsr_step;
    logic [31:0] cnt;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic        found;

    assign lfsr_step = {lfsr[0] ^ lfsr[1] ^ lfsr[3] ^ lfsr[4], lfsr[63:1]};
    assign ready     = state == READY;

    // first requesting lane at or after ptr, wrapping around
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[(int'(ptr) + i) % N_REQ]) begin
                found = 1'b1;
                win   = PW'((int'(ptr) + i) % N_REQ);
            end
        end
    end

    // sequencing: warm-up, grant from READY, then refill RAND_W fresh bits
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr       <= SEED;
            state      <= WARM;
            cnt        <= 32'(WARMUP);
            ptr        <= '0;
            grant      <= '0;
            rand_valid <= 1'b0;
            rand_out   <= '0;
        end else if (seed_valid) begin
            lfsr       <= (seed_in == 64'd0) ? SEED : seed_in;
            cnt        <= 32'(WARMUP);
            state      <= WARM;
            grant      <= '0;
            rand_valid <= 1'b0;
        end else begin
            case (state)
                READY: begin
                    if (found) begin
                        grant      <= N_REQ'(1) << win;
                        rand_valid <= 1'b1;
                        rand_out   <= lfsr[RAND_W-1:0];
                        ptr        <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
                        cnt        <= 32'(RAND_W);
                        state      <= REFILL;
                    end else begin
                        grant      <= '0;
                        rand_valid <= 1'b0;
                    end
                end
                WARM, REFILL: begin
                    lfsr       <= lfsr_step;
                    cnt        <= cnt - 1;
                    grant      <= '0;
                    rand_valid <= 1'b0;
                    if (cnt == 1) state <= READY;
                end
                default: state <= WARM;
            endcase
        end
    end
endmodule
